// File: rtl/sram_fifo_ctrl_if.sv
// Stream and SRAM-port bundle for sram_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding logic.
interface sram_fifo_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned W_ADDR  = $clog2(DEPTH);
    localparam int unsigned W_LEVEL = $clog2(DEPTH + 3);

    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [W_LEVEL-1:0] level;
    logic [W_ADDR-1:0]  sram_waddr;
    logic [WIDTH-1:0]   sram_wdata;
    logic               sram_wen;
    logic [W_ADDR-1:0]  sram_raddr;
    logic               sram_ren;
    logic [WIDTH-1:0]   sram_rdata;

    modport slave (
        input  in_data, in_valid, out_ready, sram_rdata,
        output in_ready, out_data, out_valid, level,
        output sram_waddr, sram_wdata, sram_wen, sram_raddr, sram_ren
    );

    modport master (
        output in_data, in_valid, out_ready, sram_rdata,
        input  in_ready, out_data, out_valid, level,
        input  sram_waddr, sram_wdata, sram_wen, sram_raddr, sram_ren
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller sequencing an external 1R1W synchronous SRAM behind
// valid/ready streams. A 2-entry head/skid buffer hides the SRAM read latency.
// Optional macro SRAM_FIFO_CTRL_BYPASS_EN: when the FIFO holds nothing in the
// SRAM or in flight, pushed beats go straight into the output buffer.
module sram_fifo_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_fifo_ctrl_if.slave bus
);
    localparam int unsigned W_ADDR  = $clog2(DEPTH);
    localparam int unsigned W_LEVEL = $clog2(DEPTH + 3);
    localparam int unsigned W_SLVL  = $clog2(DEPTH + 1);
    localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(DEPTH - 1);
    localparam logic [W_SLVL-1:0] FULL_LVL  = W_SLVL'(DEPTH);

    logic [W_ADDR-1:0] wptr_q, wptr_d;
    logic [W_ADDR-1:0] rptr_q, rptr_d;
    logic [W_SLVL-1:0] sram_level_q, sram_level_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        buf_level_q, buf_level_d;
    logic [WIDTH-1:0]  head_q, head_d;
    logic [WIDTH-1:0]  skid_q, skid_d;

    logic              in_ready_c;
    logic              push;
    logic              pop;
    logic              byp;
    logic              wen;
    logic              ren;
    logic              enq;
    logic [2:0]        occ_after_pop;
    logic [WIDTH-1:0]  enq_data;

    // Handshakes, read-issue and bypass decisions
    always_comb begin
        in_ready_c    = (sram_level_q != FULL_LVL);
        push          = rst_n && bus.in_valid && in_ready_c;
        pop           = (buf_level_q != 2'd0) && bus.out_ready;
        occ_after_pop = 3'(buf_level_q) + 3'(inflight_q) - 3'(pop);
        ren           = (sram_level_q != '0) && (occ_after_pop < 3'd2);
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
        byp           = push && (sram_level_q == '0) && !inflight_q
                        && ((3'(buf_level_q) - 3'(pop)) < 3'd2);
`else
        byp           = 1'b0;
`endif
        wen           = push && !byp;
        enq           = inflight_q || byp;
        enq_data      = inflight_q ? bus.sram_rdata : bus.in_data;
    end

    // Next-state for pointers, levels and the head/skid buffer
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        sram_level_d = sram_level_q + W_SLVL'(wen) - W_SLVL'(ren);
        inflight_d   = ren;
        buf_level_d  = buf_level_q;
        head_d       = head_q;
        skid_d       = skid_q;

        if (wen) begin
            wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + W_ADDR'(1);
        end
        if (ren) begin
            rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + W_ADDR'(1);
        end

        // Pop shifts skid into head; an enqueue lands in the first free slot
        case ({pop, enq})
            2'b10: begin
                head_d      = skid_q;
                buf_level_d = buf_level_q - 2'd1;
            end
            2'b01: begin
                if (buf_level_q == 2'd0) begin
                    head_d = enq_data;
                end else begin
                    skid_d = enq_data;
                end
                buf_level_d = buf_level_q + 2'd1;
            end
            2'b11: begin
                if (buf_level_q == 2'd1) begin
                    head_d = enq_data;
                end else begin
                    head_d = skid_q;
                    skid_d = enq_data;
                end
            end
            default: ;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            sram_level_q <= '0;
            inflight_q   <= 1'b0;
            buf_level_q  <= 2'd0;
            head_q       <= '0;
            skid_q       <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            sram_level_q <= sram_level_d;
            inflight_q   <= inflight_d;
            buf_level_q  <= buf_level_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = (buf_level_q != 2'd0);
    assign bus.out_data   = head_q;
    assign bus.level      = W_LEVEL'(sram_level_q) + W_LEVEL'(inflight_q) + W_LEVEL'(buf_level_q);
    assign bus.sram_waddr = wptr_q;
    assign bus.sram_wdata = bus.in_data;
    assign bus.sram_wen   = wen;
    assign bus.sram_raddr = rptr_q;
    assign bus.sram_ren   = ren;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl: DEPTH=256 instance (a) and DEPTH=5 instance (b),
// each with a behavioural one-cycle-latency SRAM.
module tb_sram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sram_fifo_ctrl_if #(.WIDTH(32), .DEPTH(256)) ifa ();
    sram_fifo_ctrl_if #(.WIDTH(32), .DEPTH(5))   ifb ();

    sram_fifo_ctrl #(.WIDTH(32), .DEPTH(256)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    sram_fifo_ctrl #(.WIDTH(32), .DEPTH(5))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [5];

    always @(posedge clk) begin
        if (ifa.sram_wen) mem_a[ifa.sram_waddr] <= ifa.sram_wdata;
        if (ifa.sram_ren) ifa.sram_rdata <= mem_a[ifa.sram_raddr];
        if (ifb.sram_wen && ifb.sram_waddr < 3'd5) mem_b[ifb.sram_waddr] <= ifb.sram_wdata;
        if (ifb.sram_ren && ifb.sram_raddr < 3'd5) ifb.sram_rdata <= mem_b[ifb.sram_raddr];
    end

`ifdef SRAM_FIFO_CTRL_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int lvl_a = 0, lvl_b = 0;
    int npop_a = 0, npop_b = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic acc_a, pop_a, ov_a, ir_a, acc_b, pop_b;
    logic [31:0] dat_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes, score data and level, advance to next negedge
    task automatic tick();
        #1;
        acc_a = rst_n && ifa.in_valid && ifa.in_ready;
        pop_a = rst_n && ifa.out_valid && ifa.out_ready;
        ov_a  = ifa.out_valid;
        ir_a  = ifa.in_ready;
        dat_a = ifa.out_data;
        acc_b = rst_n && ifb.in_valid && ifb.in_ready;
        pop_b = rst_n && ifb.out_valid && ifb.out_ready;
        if (rst_n) begin
            check("a_level", 32'(ifa.level), 32'(lvl_a));
            check("b_level", 32'(ifb.level), 32'(lvl_b));
            if (ifb.sram_wen) check("b_waddr_range", 32'(ifb.sram_waddr < 3'd5), 32'd1);
            if (ifb.sram_ren) check("b_raddr_range", 32'(ifb.sram_raddr < 3'd5), 32'd1);
        end
        if (pop_a) begin
            check("a_pop_nonempty", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) check("a_data", ifa.out_data, q_a.pop_front());
            npop_a++;
        end
        if (pop_b) begin
            check("b_pop_nonempty", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) check("b_data", ifb.out_data, q_b.pop_front());
            npop_b++;
        end
        if (acc_a) q_a.push_back(ifa.in_data);
        if (acc_b) q_b.push_back(ifb.in_data);
        lvl_a = lvl_a + int'(acc_a) - int'(pop_a);
        lvl_b = lvl_b + int'(acc_b) - int'(pop_b);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
        #3;
        check("rst_in_ready",  32'(ifa.in_ready),  32'd1);
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_level",     32'(ifa.level),     32'd0);
        check("rst_wen",       32'(ifa.sram_wen),  32'd0);
        check("rst_ren",       32'(ifa.sram_ren),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Three back-to-back beats with the consumer always ready
        for (int c = 0; c < 8; c++) begin
            ifa.in_valid  = (c < 3);
            ifa.in_data   = 32'h11 * 32'(c + 1);
            ifa.out_ready = 1'b1;
            tick();
            check("t1_out_valid", 32'(ov_a), 32'((c >= LAT) && (c < LAT + 3)));
            if (c == LAT) check("t1_first_data", dat_a, 32'h11);
        end
        check("t1_pops", 32'(npop_a), 32'd3);

        // Fill to capacity (258) with the consumer stalled
        ifa.out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 400 && n < 258; c++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 32'(n);
            tick();
            if (acc_a) n++;
        end
        check("full_count", 32'(n), 32'd258);
        ifa.in_data = 32'h999;
        tick();
        check("full_in_ready", 32'(ir_a),         32'd0);
        check("full_level",    32'(ifa.level),    32'd258);
        check("full_ren_idle", 32'(ifa.sram_ren), 32'd0);
        check("full_ov",       32'(ov_a),         32'd1);

        // Single pop re-opens the input within two cycles
        npop_a = 0;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (ir_a) break;
        end
        check("full_reenable", 32'(ir_a), 32'd1);
        ifa.out_ready = 1'b1;
        for (int c = 0; c < 400 && lvl_a != 0; c++) tick();
        check("full_drain_pops",  32'(npop_a),     32'd258);
        check("full_drain_empty", 32'(q_a.size()), 32'd0);

        // Continuous push with random back-pressure
        for (int c = 0; c < 1000; c++) begin
            ifa.in_valid  = 1'b1;
            ifa.in_data   = $urandom;
            ifa.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        for (int c = 0; c < 400 && lvl_a != 0; c++) tick();
        check("rand_drain_level", 32'(ifa.level),  32'd0);
        check("rand_drain_empty", 32'(q_a.size()), 32'd0);

        // Pointer wrap at DEPTH=5 with level held around 3..7
        n = 0;
        npop_b = 0;
        for (int c = 0; c < 300 && (n < 23 || lvl_b != 0); c++) begin
            ifb.in_valid  = (n < 23) && (lvl_b < 7);
            ifb.in_data   = 32'h100 + 32'(n);
            ifb.out_ready = (n >= 23) || (lvl_b > 3);
            tick();
            if (acc_b) n++;
        end
        ifb.in_valid = 1'b0;
        check("wrap_pushed", 32'(n),          32'd23);
        check("wrap_pops",   32'(npop_b),     32'd23);
        check("wrap_empty",  32'(q_b.size()), 32'd0);
        check("wrap_level",  32'(ifb.level),  32'd0);

        // Reset mid-stream discards contents
        ifa.out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 30 && n < 10; c++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 32'h500 + 32'(n);
            tick();
            if (acc_a) n++;
        end
        check("mid_level_pre", 32'(ifa.level), 32'd10);
        ifa.in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(ifa.in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("mid_rst_level",     32'(ifa.level),     32'd0);
        check("mid_rst_wen",       32'(ifa.sram_wen),  32'd0);
        check("mid_rst_ren",       32'(ifa.sram_ren),  32'd0);
        ifa.in_valid = 1'b0;
        q_a.delete(); q_b.delete();
        lvl_a = 0; lvl_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        npop_a = 0;
        ifa.in_valid = 1'b1;
        ifa.in_data  = 32'hAA;
        tick();
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("mid_post_pops",  32'(npop_a),    32'd1);
        check("mid_post_level", 32'(ifa.level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
